// File: rtl/aes_block_sequencer.sv
// aes_block_sequencer: packs 32-bit input words into 128-bit blocks for the aes core and streams the result back as 32-bit words.
// Latency: 4th accepted input word -> core_en the next cycle; core_done rising edge captured -> first output word the next cycle.
// Backpressure: in_ready is low from START until all 4 result words have drained; out_data/out_last hold while out_ready is low.
// Build option AES_CBC_EN: adds a CBC chain register plus iv_load/iv_in ports; the default build is plain ECB.
module aes_block_sequencer #(
    parameter int KEY_BITS = 192
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_load,
    input  logic [KEY_BITS-1:0] key_in,
`ifdef AES_CBC_EN
    input  logic                iv_load,
    input  logic [127:0]        iv_in,
`endif
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_data,
    output logic                out_last,
    output logic                core_en,
    output logic [127:0]        core_state,
    output logic [KEY_BITS-1:0] core_key,
    input  logic                core_done,
    input  logic [127:0]        core_state_out,
    output logic                busy
);

    generate
        if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
            $error("aes_block_sequencer: KEY_BITS must be 128, 192 or 256");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [1:0]      cnt_q;       // word index: input slot in LOAD, output word in DRAIN
    logic [2:0][31:0] slot_q;     // first three words of the block; the 4th goes straight to core_state
    logic [127:0]    result_q;
    logic            done_q;
    logic            in_fire;
    logic            out_fire;
    logic            done_rise;
    logic            idle_empty;
    logic [127:0]    block_pt;
    logic [127:0]    block_tx;

    assign in_fire    = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;
    // A level already high when RUN is entered has done_q set, so only a fresh 0->1 edge counts.
    assign done_rise  = (state_q == S_RUN) & core_done & ~done_q;
    assign idle_empty = (state_q == S_LOAD) & (cnt_q == 2'd0);
    assign block_pt   = {in_data, slot_q[2], slot_q[1], slot_q[0]};

`ifdef AES_CBC_EN
    logic [127:0] chain_q;

    assign block_tx = block_pt ^ chain_q;

    // Chain register: previous ciphertext at capture, otherwise IV load (wins) or clear on key load while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else if (done_rise) begin
            chain_q <= core_state_out;
        end else if (idle_empty && iv_load) begin
            chain_q <= iv_in;
        end else if (idle_empty && key_load) begin
            chain_q <= '0;
        end
    end
`else
    assign block_tx = block_pt;
`endif

    // State register and one-cycle history of core_done for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LOAD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= core_done;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        core_en   = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                in_ready = ~rst;
                if (in_fire && cnt_q == 2'd3) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                core_en = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                core_en = 1'b1;
                if (done_rise) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                if (out_fire && cnt_q == 2'd3) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    assign out_data = out_valid ? result_q[{cnt_q, 5'd0} +: 32] : 32'd0;
    assign out_last = out_valid & (cnt_q == 2'd3);
    assign busy     = ~idle_empty;

    // Word counter, input slots, block sent to the core and captured result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= 2'd0;
            slot_q     <= '0;
            core_state <= '0;
            result_q   <= '0;
        end else begin
            if (in_fire || out_fire) begin
                cnt_q <= cnt_q + 2'd1;
            end
            if (in_fire && cnt_q != 2'd3) begin
                slot_q[cnt_q] <= in_data;
            end
            if (in_fire && cnt_q == 2'd3) begin
                core_state <= block_tx;
            end
            if (done_rise) begin
                result_q <= core_state_out;
            end
        end
    end

    // Key register: only loaded while idle with no words held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_key <= '0;
        end else if (idle_empty && key_load) begin
            core_key <= key_in;
        end
    end

endmodule

// File: tb/tb_aes_block_sequencer.sv
`timescale 1ns/1ps
// tb_aes_block_sequencer: randomized blocks against a block-level reference model (expected core block, expected output words).
// Latency: checks core_en one cycle after the 4th accept and first output one cycle after the core_done edge.
// Backpressure: drives always-ready, toggling and random out_ready, and holds in_valid high through busy phases.
module tb_aes_block_sequencer;
    localparam int KB = 192;
`ifdef AES_CBC_EN
    localparam bit CBC = 1'b1;
`else
    localparam bit CBC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          key_load;
    logic [KB-1:0] key_in;
`ifdef AES_CBC_EN
    logic          iv_load;
    logic [127:0]  iv_in;
`endif
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          out_last;
    logic          core_en;
    logic [127:0]  core_state;
    logic [KB-1:0] core_key;
    logic          core_done;
    logic [127:0]  core_state_out;
    logic          busy;

    int            tests = 0;
    int            fails = 0;
    logic [127:0]  m_chain;      // reference chaining value (remains zero in ECB)
    logic [127:0]  core_result;  // what the stand-in core will return for the current block
    bit            stale_done;   // hold core_done high while the core is idle
    int            en_cnt;

    always #5 clk = ~clk;

    aes_block_sequencer #(.KEY_BITS(KB)) dut (
        .clk            (clk),
        .rst            (rst),
        .key_load       (key_load),
        .key_in         (key_in),
`ifdef AES_CBC_EN
        .iv_load        (iv_load),
        .iv_in          (iv_in),
`endif
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .core_en        (core_en),
        .core_state     (core_state),
        .core_key       (core_key),
        .core_done      (core_done),
        .core_state_out (core_state_out),
        .busy           (busy)
    );

    // Stand-in aes core: raises done (level) 12 cycles after enable, with junk on the result bus before that
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_done      <= 1'b0;
            core_state_out <= '0;
            en_cnt         <= 0;
        end else if (!core_en) begin
            en_cnt         <= 0;
            core_done      <= stale_done;
            core_state_out <= ~core_result;
        end else begin
            en_cnt <= en_cnt + 1;
            if (en_cnt == 2) core_done <= 1'b0;
            if (en_cnt == 11) begin
                core_done      <= 1'b1;
                core_state_out <= core_result;
            end
        end
    end

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [KB-1:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Offer words first..last of blk; returns just after the accepting clock edge with in_valid still high
    task automatic send_words(input logic [127:0] blk, input int first, input int last, input bit gaps);
        int guard;
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = $urandom();
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = blk[32*i +: 32];
            guard = 0;
            while (in_ready !== 1'b1 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) begin
                tests++; fails++;
                $display("FAIL in_ready_timeout word=%0d in_ready=%b required=1", i, in_ready);
            end
            @(posedge clk);
        end
    endtask

    // Completes a block whose 4th word was just accepted: checks the core handoff, latency and the output stream
    task automatic finish_block(input logic [127:0] exp_state, input logic [127:0] r, input int omode, input bit hold);
        int  lat;
        int  k;
        int  guard;
        bit  rdy;
        @(negedge clk);
        if (hold) in_data = $urandom(); else in_valid = 1'b0;
        tests++;
        if (core_en !== 1'b1) begin
            fails++; $display("FAIL core_en_after_4th got=%b required=1", core_en);
        end
        tests++;
        if (core_state !== exp_state) begin
            fails++; $display("FAIL core_state got=%h required=%h", core_state, exp_state);
        end
        tests++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL start_flags in_ready=%b busy=%b required 0/1", in_ready, busy);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (hold) begin
                tests++;
                if (in_ready !== 1'b0) begin
                    fails++; $display("FAIL in_ready_while_busy got=%b required=0", in_ready);
                end
                in_data = $urandom();
            end
            @(negedge clk);
            lat++;
        end
        tests++;
        if (lat != 13) begin
            fails++; $display("FAIL out_valid_latency got=%0d required=13", lat);
        end
        tests++;
        if (core_en !== 1'b0) begin
            fails++; $display("FAIL core_en_after_done got=%b required=0", core_en);
        end
        k = 0;
        guard = 0;
        while (k < 4 && guard < 100) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== r[32*k +: 32] || out_last !== (k == 3)) begin
                fails++;
                $display("FAIL drain_word%0d valid=%b data=%h last=%b required 1/%h/%b",
                         k, out_valid, out_data, out_last, r[32*k +: 32], (k == 3));
            end
            case (omode)
                0:       rdy = 1'b1;
                1:       rdy = (guard % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (hold && rdy && k == 3) in_valid = 1'b0;
            else if (hold) in_data = $urandom();
            if (rdy) k++;
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        tests++;
        if (k < 4 || out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL drain_end words=%0d out_valid=%b out_last=%b in_ready=%b busy=%b required 4/0/0/1/0",
                     k, out_valid, out_last, in_ready, busy);
        end
        if (CBC) m_chain = r;
    endtask

    task automatic test_reset();
        #23;
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || core_en !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags in_ready=%b out_valid=%b out_last=%b core_en=%b busy=%b required all 0",
                     in_ready, out_valid, out_last, core_en, busy);
        end
        tests++;
        if (core_state !== 128'd0 || core_key !== '0 || out_data !== 32'd0) begin
            fails++;
            $display("FAIL reset_data core_state=%h core_key=%h out_data=%h required 0", core_state, core_key, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL ready_after_reset got=%b required=1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [127:0] blk;
        logic [127:0] r;
        blk = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
        r = rand128();
        core_result = r;
        send_words(blk, 0, 3, 1'b0);
        finish_block(blk ^ m_chain, r, 0, 1'b0);
    endtask

    task automatic test_key();
        logic [KB-1:0] k1;
        logic [KB-1:0] k2;
        logic [127:0]  blk;
        logic [127:0]  r;
        k1 = rand_key(); k2 = rand_key(); blk = rand128(); r = rand128();
        core_result = r;
        @(negedge clk);
        key_load = 1'b1; key_in = k1;
        @(negedge clk);
        key_load = 1'b0;
        if (CBC) m_chain = '0;
        tests++;
        if (core_key !== k1) begin
            fails++; $display("FAIL key_capture got=%h required=%h", core_key, k1);
        end
        send_words(blk, 0, 0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; key_load = 1'b1; key_in = k2;
        @(negedge clk);
        key_load = 1'b0;
        tests++;
        if (core_key !== k1) begin
            fails++; $display("FAIL key_midblock got=%h required=%h", core_key, k1);
        end
        send_words(blk, 1, 3, 1'b0);
        fork
            finish_block(blk ^ m_chain, r, 0, 1'b0);
            begin
                repeat (4) @(negedge clk);
                key_load = 1'b1; key_in = k2;
                @(negedge clk);
                key_load = 1'b0;
            end
        join
        tests++;
        if (core_key !== k1) begin
            fails++; $display("FAIL key_in_run got=%h required=%h", core_key, k1);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] blk;
        logic [127:0] r;
        blk = rand128(); r = rand128();
        core_result = r;
        send_words(blk, 0, 3, 1'b0);
        finish_block(blk ^ m_chain, r, 1, 1'b0);
    endtask

    task automatic test_hold_valid();
        logic [127:0] blk;
        logic [127:0] r;
        blk = rand128(); r = rand128();
        core_result = r;
        send_words(blk, 0, 3, 1'b0);
        finish_block(blk ^ m_chain, r, 2, 1'b1);
        blk = rand128(); r = rand128();
        core_result = r;
        send_words(blk, 0, 3, 1'b1);
        finish_block(blk ^ m_chain, r, 0, 1'b0);
    endtask

    task automatic test_stale_done();
        logic [127:0] blk;
        logic [127:0] r;
        blk = rand128(); r = rand128();
        core_result = r;
        stale_done = 1'b1;
        send_words(blk, 0, 3, 1'b0);
        finish_block(blk ^ m_chain, r, 0, 1'b0);
        stale_done = 1'b0;
    endtask

    task automatic test_random();
        logic [127:0] blk;
        logic [127:0] r;
        for (int n = 0; n < 6; n++) begin
            blk = rand128(); r = rand128();
            core_result = r;
            send_words(blk, 0, 3, 1'b1);
            finish_block(blk ^ m_chain, r, $urandom_range(0, 2), 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] blk;
        logic [127:0] r;
        // reset after two accepted words
        blk = rand128();
        send_words(blk, 0, 1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || core_en !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
            fails++;
            $display("FAIL reset_midload_flags in_ready=%b out_valid=%b core_en=%b busy=%b out_last=%b required all 0",
                     in_ready, out_valid, core_en, busy, out_last);
        end
        tests++;
        if (core_state !== 128'd0 || core_key !== '0 || out_data !== 32'd0) begin
            fails++;
            $display("FAIL reset_midload_data core_state=%h core_key=%h out_data=%h required 0", core_state, core_key, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        m_chain = '0;
        blk = rand128(); r = rand128();
        core_result = r;
        send_words(blk, 0, 3, 1'b1);
        finish_block(blk ^ m_chain, r, 2, 1'b0);
        // reset while the core is running
        blk = rand128();
        send_words(blk, 0, 3, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (core_en !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || core_state !== 128'd0) begin
            fails++;
            $display("FAIL reset_in_run core_en=%b busy=%b out_valid=%b in_ready=%b core_state=%h required 0",
                     core_en, busy, out_valid, in_ready, core_state);
        end
        @(negedge clk);
        rst = 1'b0;
        m_chain = '0;
        blk = rand128(); r = rand128();
        core_result = r;
        send_words(blk, 0, 3, 1'b0);
        finish_block(blk ^ m_chain, r, 0, 1'b0);
    endtask

    task automatic test_cbc();
`ifdef AES_CBC_EN
        logic [127:0] p;
        logic [127:0] iv;
        logic [127:0] r;
        p = rand128(); iv = rand128();
        @(negedge clk);
        iv_load = 1'b1; iv_in = '0;
        @(negedge clk);
        iv_load = 1'b0;
        m_chain = '0;
        for (int n = 0; n < 2; n++) begin
            r = rand128();
            core_result = r;
            send_words(p, 0, 3, 1'b0);
            finish_block(p ^ m_chain, r, 2, 1'b0);
        end
        // iv_load and key_load together: iv wins
        @(negedge clk);
        iv_load = 1'b1; iv_in = iv; key_load = 1'b1; key_in = rand_key();
        @(negedge clk);
        iv_load = 1'b0; key_load = 1'b0;
        m_chain = iv;
        r = rand128();
        core_result = r;
        send_words(p, 0, 3, 1'b0);
        finish_block(p ^ m_chain, r, 0, 1'b0);
        // key_load alone clears the chain
        @(negedge clk);
        key_load = 1'b1; key_in = rand_key();
        @(negedge clk);
        key_load = 1'b0;
        m_chain = '0;
        r = rand128();
        core_result = r;
        send_words(p, 0, 3, 1'b0);
        finish_block(p ^ m_chain, r, 0, 1'b0);
`endif
    endtask

    initial begin
        in_valid    = 1'b0;
        in_data     = 32'd0;
        out_ready   = 1'b0;
        key_load    = 1'b0;
        key_in      = '0;
`ifdef AES_CBC_EN
        iv_load     = 1'b0;
        iv_in       = '0;
`endif
        core_result = '0;
        stale_done  = 1'b0;
        m_chain     = '0;
        test_reset();
        test_basic();
        test_key();
        test_backpressure();
        test_hold_valid();
        test_stale_done();
        test_random();
        test_reset_mid();
        test_cbc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
